fetch_stage_ctrl: RTL and testbench
===================================

// Module: fetch_stage_ctrl
// PURPOSE
//  Consumer end of the load-use stall / branch-flush interface: owns the PC register and IF/ID pipeline register.
//  Honours stall (hold PC and IF/ID), flush (squash IF/ID to NOP, redirect PC) and start gating.
//  Sits between instruction memory and the ID stage; counts stall and flush events for performance debug.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  CNT_W      16             width of the saturating stall/flush event counters
// PORTS
//  clk_i            in   1       clock, all state updates on rising edge
//  rst_i            in   1       asynchronous reset, active-low
//  start_i          in   1       1 = pipeline running; 0 = fetch frozen
//  stall_i          in   1       hold request (PC and IF/ID), 1 = stall
//  flush_i          in   1       branch taken in ID: squash IF/ID, redirect PC
//  branch_target_i  in   32      redirect address, bits [1:0] ignored
//  instr_i          in   32      instruction memory data for address pc_o (combinational read)
//  pc_o             out  32      current fetch address to instruction memory
//  IF_ID_pc_o       out  32      PC+4 of the instruction held in IF/ID
//  IF_ID_instr_o    out  32      instruction held in IF/ID (32'h0 = NOP bubble)
//  IF_ID_valid_o    out  1       1 = IF/ID holds a real instruction
//  stall_cnt_o      out  CNT_W   number of cycles with an honoured stall, saturating
//  flush_cnt_o      out  CNT_W   number of honoured flushes, saturating
// BEHAVIOUR
//  Reset (rst_i=0, async): pc_o=RESET_PC; IF_ID_pc_o=0; IF_ID_instr_o=0; IF_ID_valid_o=0; counters=0; FSM=IDLE.
//  FSM: IDLE -> RUN when start_i=1 at a clock edge; RUN -> IDLE when start_i=0; only reset otherwise leaves RUN.
//  IDLE cycle: PC holds; IF/ID loads bubble (instr 0, pc 0, valid 0); stall_i/flush_i ignored, not counted.
//  RUN, per edge, priority stall > flush > normal:
//   stall_i=1:  PC holds; IF/ID holds all fields; stall_cnt_o+1; flush_i ignored (branch in ID not final).
//   flush_i=1:  pc_o <= {branch_target_i[31:2],2'b00}; IF/ID <= bubble; flush_cnt_o+1.
//   normal:     pc_o <= pc_o+4; IF_ID_instr_o <= instr_i; IF_ID_pc_o <= pc_o+4; IF_ID_valid_o <= 1.
//  Latency: instruction at address A appears on IF_ID_instr_o one edge after pc_o=A (no stall).
//  pc_o+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no flag raised.
//  Counters saturate at all-ones, never wrap.
//  stall_i held N consecutive cycles -> exactly N holds, stall_cnt_o += N; first non-stall edge resumes normally.
//  Reset asserted mid-stall or mid-flush: all state returns to reset values immediately; no pending action survives.
//  All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
//  Shared package pipeline_pkg: NOP_INSTR (32'h0), PC_STEP (32'd4), FSM state encoding (IDLE, RUN).
//  One natural sub-module: sat_counter (CNT_W, inc_i, cnt_o), instantiated twice for stall and flush.
//  PC register, IF/ID register and FSM live in this module.
// TESTING
//  1. Reset, start_i=1, imem returns A at addr 0, B at 4 -> pc_o 0,4,8; IF_ID_instr_o A then B; valid=1.
//  2. Stall 2 cycles at pc_o=8 -> pc_o stays 8; IF/ID holds B; stall_cnt_o=2; then pc_o=12 next edge.
//  3. flush_i=1, branch_target_i=32'h0000_0103 -> pc_o=32'h100; IF_ID_instr_o=0, valid=0; flush_cnt_o=1.
//  4. stall_i=1 and flush_i=1 together -> hold wins; pc_o unchanged; stall_cnt_o+1; flush_cnt_o unchanged.
//  5. Force pc_o=32'hFFFF_FFFC via flush, then a normal edge -> pc_o=0, IF_ID_pc_o=0, valid=1.
//  6. rst_i low mid-stall (async, between edges) -> outputs reset at once; CNT_W=2 -> 5 stalls read stall_cnt_o=3.

Source files
------------

// File: rtl/fetch_stage_ctrl_pkg.sv
// Purpose: shared constants and FSM encoding for the fetch stage and its neighbours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Branch targets are word aligned; low two address bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_ctrl_if.sv
// Purpose: bundles the fetch control, imem and IF/ID signals of the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: stall_i is the hold request from ID; no other flow control.
interface fetch_stage_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             stall_i;
    logic             flush_i;
    logic [31:0]      branch_target_i;
    logic [31:0]      instr_i;
    logic [31:0]      pc_o;
    logic [31:0]      IF_ID_pc_o;
    logic [31:0]      IF_ID_instr_o;
    logic             IF_ID_valid_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    // Driver side: pipeline control, ID stage and instruction memory.
    modport master (
        output start_i, stall_i, flush_i, branch_target_i, instr_i,
        input  pc_o, IF_ID_pc_o, IF_ID_instr_o, IF_ID_valid_o, stall_cnt_o, flush_cnt_o
    );

    // Fetch stage side.
    modport slave (
        input  start_i, stall_i, flush_i, branch_target_i, instr_i,
        output pc_o, IF_ID_pc_o, IF_ID_instr_o, IF_ID_valid_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/fetch_stage_ctrl_sat_counter.sv
// Purpose: event counter that sticks at all-ones instead of wrapping.
// Latency: count visible one edge after inc_i.
// Backpressure: none; increments beyond saturation are dropped.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Increment on request unless already at the maximum value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Purpose: PC register, IF/ID register and run/idle FSM honouring stall and flush.
// Latency: instruction at pc_o appears in IF/ID one edge later.
// Backpressure: stall_i holds PC and IF/ID (beats flush); idle loads bubbles.
module fetch_stage_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fetch_stage_ctrl_if.slave bus
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  ifid_pc_q;
    logic [31:0]  ifid_instr_q;
    logic         ifid_valid_q;
    logic         stall_ev;
    logic         flush_ev;

    // Events only count while running; a stall masks a concurrent flush
    // because the branch in ID is not yet final.
    assign stall_ev = (state_q == RUN) && bus.stall_i;
    assign flush_ev = (state_q == RUN) && !bus.stall_i && bus.flush_i;

    // FSM plus PC and IF/ID registers; action chosen by the current state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ifid_pc_q    <= '0;
                    ifid_instr_q <= NOP_INSTR;
                    ifid_valid_q <= 1'b0;
                    if (bus.start_i) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.start_i) begin
                        state_q <= IDLE;
                    end
                    if (bus.stall_i) begin
                        // Hold everything.
                        pc_q <= pc_q;
                    end else if (bus.flush_i) begin
                        pc_q         <= align_pc(bus.branch_target_i);
                        ifid_pc_q    <= '0;
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                    end else begin
                        pc_q         <= pc_q + PC_STEP;
                        ifid_pc_q    <= pc_q + PC_STEP;
                        ifid_instr_q <= bus.instr_i;
                        ifid_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_ev),
        .cnt_o (bus.stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_ev),
        .cnt_o (bus.flush_cnt_o)
    );

    assign bus.pc_o          = pc_q;
    assign bus.IF_ID_pc_o    = ifid_pc_q;
    assign bus.IF_ID_instr_o = ifid_instr_q;
    assign bus.IF_ID_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Purpose: directed vector bench for fetch_stage_ctrl with a 2-bit counter build.
// Latency: checks one edge after each applied vector.
// Backpressure: exercises stall, flush, stall+flush, wrap, saturation, async reset.
module tb_fetch_stage_ctrl;

    localparam int CNT_W = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    fetch_stage_ctrl_if #(.CNT_W(CNT_W)) bus ();

    fetch_stage_ctrl #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Instruction memory model: data is a recognisable tag of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign bus.instr_i = imem(bus.pc_o);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ifpc,
                           input logic [31:0] instr, input logic valid,
                           input logic [1:0] sc, input logic [1:0] fc);
        chk({tag, ".pc"},    bus.pc_o,                 pc);
        chk({tag, ".ifpc"},  bus.IF_ID_pc_o,           ifpc);
        chk({tag, ".instr"}, bus.IF_ID_instr_o,        instr);
        chk({tag, ".valid"}, 32'(bus.IF_ID_valid_o),   32'(valid));
        chk({tag, ".scnt"},  32'(bus.stall_cnt_o),     32'(sc));
        chk({tag, ".fcnt"},  32'(bus.flush_cnt_o),     32'(fc));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        valid;
        logic [1:0]  sc;
        logic [1:0]  fc;
    } vec_t;

    vec_t vecs [15];

    initial begin
        // stall, flush, target | pc, IF_ID_pc, IF_ID_instr, valid, stall_cnt, flush_cnt
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0,   32'h0,         1'b0, 2'd0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h4,   32'hC0DE_0000, 1'b1, 2'd0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         32'h8,         32'h8,   32'hC0DE_0004, 1'b1, 2'd0, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'h8,   32'hC0DE_0004, 1'b1, 2'd1, 2'd0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'h8,   32'hC0DE_0004, 1'b1, 2'd2, 2'd0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         32'hC,         32'hC,   32'hC0DE_0008, 1'b1, 2'd2, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 32'h103,       32'h100,       32'h0,   32'h0,         1'b0, 2'd2, 2'd1};
        vecs[7]  = '{1'b1, 1'b1, 32'h200,       32'h100,       32'h0,   32'h0,         1'b0, 2'd3, 2'd1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,         32'h104,       32'h104, 32'hC0DE_0100, 1'b1, 2'd3, 2'd1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,         32'h104,       32'h104, 32'hC0DE_0100, 1'b1, 2'd3, 2'd1};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,   32'h0,         1'b0, 2'd3, 2'd2};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0,   32'hC0DE_FFFC, 1'b1, 2'd3, 2'd2};
        vecs[12] = '{1'b0, 1'b0, 32'h0,         32'h4,         32'h4,   32'hC0DE_0000, 1'b1, 2'd3, 2'd2};
        vecs[13] = '{1'b0, 1'b1, 32'h10,        32'h10,        32'h0,   32'h0,         1'b0, 2'd3, 2'd3};
        vecs[14] = '{1'b0, 1'b1, 32'h22,        32'h20,        32'h0,   32'h0,         1'b0, 2'd3, 2'd3};

        bus.start_i         = 1'b0;
        bus.stall_i         = 1'b0;
        bus.flush_i         = 1'b0;
        bus.branch_target_i = 32'h0;

        // Reset state, both before and across a clock edge.
        #2;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0);
        step();
        chk_all("reset_edge", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0);
        #3;
        rst_i       = 1'b1;
        bus.start_i = 1'b1;

        // Table-driven run: fetch, stall, flush, stall+flush, wrap, saturation.
        for (int i = 0; i < 15; i++) begin
            bus.stall_i         = vecs[i].stall;
            bus.flush_i         = vecs[i].flush;
            bus.branch_target_i = vecs[i].tgt;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ifpc, vecs[i].instr,
                    vecs[i].valid, vecs[i].sc, vecs[i].fc);
        end

        // Async reset in the middle of a stall.
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        step();
        chk_all("pre_rst", 32'h24, 32'h24, 32'hC0DE_0020, 1'b1, 2'd3, 2'd3);
        bus.stall_i = 1'b1;
        step();
        #3;
        rst_i = 1'b0;
        #1;
        chk_all("mid_stall_rst", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0);
        bus.start_i         = 1'b0;
        bus.flush_i         = 1'b1;
        bus.branch_target_i = 32'h100;
        #2;
        rst_i = 1'b1;

        // Idle: stall and flush ignored and not counted.
        step();
        chk_all("idle", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0);

        // Enter RUN, then 5 stalls against a 2-bit counter.
        bus.start_i = 1'b1;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        step();
        chk_all("start", 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0);
        bus.stall_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_all($sformatf("sat%0d", k), 32'h0, 32'h0, 32'h0, 1'b0,
                    (k > 3) ? 2'd3 : 2'(k), 2'd0);
        end
        bus.stall_i = 1'b0;
        step();
        chk_all("resume", 32'h4, 32'h4, 32'hC0DE_0000, 1'b1, 2'd3, 2'd0);

        // Dropping start ends in bubbles once idle.
        bus.start_i = 1'b0;
        step();
        step();
        chk("stop.valid", 32'(bus.IF_ID_valid_o), 32'h0);
        chk("stop.instr", bus.IF_ID_instr_o, 32'h0);
        chk("stop.ifpc",  bus.IF_ID_pc_o,    32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
